uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 107 ++++++++++
 tb/tb_uart_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART constants, state encoding and helpers for the transmitter and receiver.
package uart_tx_pkg;

  localparam int unsigned CLK_FREQ        = 10_000_000;
  localparam int unsigned BAUD_RATE       = 312_500;
  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned DIVISOR         = CLK_FREQ / BAUD_RATE / OVERSAMPLE;
  localparam int unsigned UART_FRAME_BITS = 10;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OS_W      = 4;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-timing generator: prescaler tick every DIVISOR clocks, bit_end every
// OVERSAMPLE ticks. Shared by the UART transmitter and receiver.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned DIVISOR    = uart_tx_pkg::DIVISOR,
  parameter int unsigned OVERSAMPLE = uart_tx_pkg::OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic bit_end
);

  localparam int unsigned PRE_W = cnt_width(DIVISOR);

  logic [PRE_W-1:0] pre_cnt;
  logic [OS_W-1:0]  os_cnt;

  // Strobes are decoded from registered counters only.
  assign tick    = (pre_cnt == PRE_W'(DIVISOR - 1));
  assign bit_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      os_cnt  <= bit_end ? '0 : os_cnt + OS_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered serial output.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = uart_tx_pkg::CLK_FREQ,
  parameter int unsigned BAUD_RATE  = uart_tx_pkg::BAUD_RATE,
  parameter int unsigned OVERSAMPLE = uart_tx_pkg::OVERSAMPLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned DIV_RATIO = CLK_FREQ / BAUD_RATE / OVERSAMPLE;

  tx_state_t             state, state_nxt;
  logic [DATA_W-1:0]     shift_q, shift_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic                  tx_nxt, ready_nxt, busy_nxt, done_nxt;
  logic                  baud_clear, baud_tick, baud_bit_end, bit_done;

  // Bit timing restarts from zero on every accepted byte.
  assign baud_clear = (state == IDLE);
  assign bit_done   = baud_tick && baud_bit_end;

  uart_baud_gen #(
    .DIVISOR    (DIV_RATIO),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .tick    (baud_tick),
    .bit_end (baud_bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx       <= tx_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = 1'b1;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_nxt   = tx_data;
          bit_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_nxt   = shift_q >> 1;
          bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Registered outputs reflect the state being entered, so tx changes on the edge.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase

    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, handshake, back-to-back and reset abort.
module tb_uart_tx;

  localparam int unsigned BIT_CLKS   = 32;
  localparam int unsigned FRAME_CLKS = 320;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         scramble;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(tx_ready), 32'd1);
  endtask

  // Offer one byte, then check tx every clock of the frame plus the done cycle.
  task automatic run_frame(input logic [7:0] data, input logic [9:0] frame, input bit scramble);
    wait_ready();
    tx_data  = data;
    tx_valid = 1'b1;
    for (int k = 0; k <= int'(FRAME_CLKS); k++) begin
      @(negedge clk);
      if (k < int'(FRAME_CLKS)) begin
        check("frame_tx", 32'(tx), 32'(frame[k / BIT_CLKS]));
        check("frame_flags", 32'({tx_ready, tx_busy, tx_done}), 32'b010);
      end else begin
        check("end_tx", 32'(tx), 32'd1);
        check("end_flags", 32'({tx_ready, tx_busy, tx_done}), 32'b101);
      end
      if (scramble && k < int'(FRAME_CLKS) - 20) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'($urandom);
      end else begin
        tx_data  = ~data;
        tx_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("done_width", 32'(tx_done), 32'd0);
  endtask

  initial begin
    logic [9:0] f0, f1, f3c;
    logic [7:0] d;
    int         done_seen;
    int         tx_low_seen;
    logic       exp_tx;
    logic       exp_done;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h5A, 10'b1_01011010_0, 1'b1};
    vecs[4] = '{8'h01, 10'b1_00000001_0, 1'b0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].frame, vecs[i].scramble);

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    f0 = 10'b1_00000000_0;
    f1 = 10'b1_11111111_0;
    wait_ready();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 0; k <= 642; k++) begin
      @(negedge clk);
      if (k < 320)      exp_tx = f0[k / BIT_CLKS];
      else if (k == 320) exp_tx = 1'b1;
      else if (k < 641)  exp_tx = f1[(k - 321) / BIT_CLKS];
      else               exp_tx = 1'b1;
      exp_done = (k == 320 || k == 641);
      check("b2b_tx", 32'(tx), 32'(exp_tx));
      check("b2b_done", 32'(tx_done), 32'(exp_done));
      if (k == 320) check("b2b_ready_gap", 32'(tx_ready), 32'd1);
      if (k == 321) check("b2b_busy2", 32'(tx_busy), 32'd1);
      if (k == 100) tx_data = 8'hFF;
      if (k == 321) tx_valid = 1'b0;
    end

    // Reset at clock 150 of a 0x3C frame aborts it.
    f3c = 10'b1_00111100_0;
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      check("abort_pre_tx", 32'(tx), 32'(f3c[k / BIT_CLKS]));
      tx_valid = 1'b0;
      if (k == 149) reset = 1'b1;
    end
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_flags", 32'({tx_ready, tx_busy, tx_done}), 32'b000);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(tx_ready), 32'd1);
    done_seen   = 0;
    tx_low_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
      if (tx !== 1'b1) tx_low_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle_tx", 32'(tx_low_seen), 32'd0);
    run_frame(8'hC3, 10'b1_11000011_0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      run_frame(d, {1'b1, d, 1'b0}, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
